gray_seq_ctrl: RTL and testbench

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

---
 rtl/gray_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_gray_seq_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl
//   Gray-code step sequencer. A run is started from IDLE with a direction
//   and a step count. Each step moves an internal binary count by one, and
//   y shows that count in gray code. A run can be paused (HOLD), resumed or
//   aborted. Every output is a register.
//
// Ports
//   clk       sole clock, rising edge
//   arst      asynchronous active-high reset
//   start     start a run from IDLE / resume from HOLD
//   stop      pause from RUN / abort from HOLD (stop beats start)
//   dir       1 = count up, 0 = count down; latched when a run starts
//   len       number of steps in the run; latched when a run starts
//   load      preset request, only honoured in IDLE (beats start)
//   load_val  preset value, in gray code
//   y         registered gray-code count
//   busy      high in RUN and HOLD
//   done      one-cycle pulse after the final step of a run
//   wrap      one-cycle pulse after a step that wraps the count
module gray_seq_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] len,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] rem;
    logic             dir_q;

    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             step_wraps;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] r;
        r[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--)
            r[i] = r[i+1] ^ g[i];
        return r;
    endfunction

    // Next count for a step. The binary counter wraps naturally modulo
    // 2^WIDTH. step_wraps flags the two boundary crossings.
    always_comb begin
        b_nxt      = dir_q ? b + 1'b1 : b - 1'b1;
        gray_nxt   = b_nxt ^ (b_nxt >> 1);
        step_wraps = dir_q ? (&b) : (b == '0);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
            b     <= '0;
            y     <= '0;
            rem   <= '0;
            dir_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            // done and wrap are single-cycle pulses.
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        b <= gray2bin(load_val);
                        y <= load_val;
                    end else if (start) begin
                        if (len != '0) begin
                            dir_q <= dir;
                            rem   <= len;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            // Zero-length run: finish at once, no step.
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= HOLD;
                    end else begin
                        b    <= b_nxt;
                        y    <= gray_nxt;
                        rem  <= rem - 1'b1;
                        wrap <= step_wraps;
                        if (rem == 1) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                HOLD: begin
                    if (stop) begin
                        // Abort: back to IDLE with no done pulse.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (start) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl
//   Directed scenarios that check against literal expected values, plus a
//   randomized run that checks against a cycle-level reference model kept
//   in this file. The model tracks an integer count and a run mode.
module tb_gray_seq_ctrl;

    localparam int W = 3;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         arst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         dir = 1'b0;
    logic [W-1:0] len = '0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic         wrap;

    int vectors = 0;
    int errors  = 0;

    gray_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .arst(arst), .start(start), .stop(stop), .dir(dir),
        .len(len), .load(load), .load_val(load_val),
        .y(y), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_FIN = 3;
    int   m_cnt, m_mode, m_left;
    logic m_up, m_done, m_wrap, m_stepped;

    function automatic int gray_to_int(input logic [W-1:0] g);
        int r = 0;
        for (int s = 0; s < W; s++) r = r ^ (int'(g) >> s);
        return r;
    endfunction

    function automatic logic [W+2:0] model_out();
        logic [W-1:0] c;
        c = m_cnt[W-1:0];
        return {c ^ (c >> 1), (m_mode == M_RUN || m_mode == M_PAUSED), m_done, m_wrap};
    endfunction

    function automatic logic [W+2:0] dut_out();
        return {y, busy, done, wrap};
    endfunction

    task automatic mdl_reset();
        m_cnt = 0; m_mode = M_IDLE; m_left = 0; m_up = 1'b0;
        m_done = 1'b0; m_wrap = 1'b0; m_stepped = 1'b0;
    endtask

    task automatic mdl_update();
        int nxt;
        m_done = 1'b0; m_wrap = 1'b0; m_stepped = 1'b0;
        case (m_mode)
            M_IDLE:
                if (load) m_cnt = gray_to_int(load_val);
                else if (start) begin
                    if (len == 0) begin m_mode = M_FIN; m_done = 1'b1; end
                    else begin m_up = dir; m_left = int'(len); m_mode = M_RUN; end
                end
            M_RUN:
                if (stop) m_mode = M_PAUSED;
                else begin
                    nxt = m_up ? m_cnt + 1 : m_cnt - 1;
                    m_wrap = (nxt < 0 || nxt >= MOD);
                    m_cnt = (nxt + MOD) % MOD;
                    m_stepped = 1'b1;
                    m_left--;
                    if (m_left == 0) begin m_mode = M_FIN; m_done = 1'b1; end
                end
            M_PAUSED:
                if (stop) m_mode = M_IDLE;
                else if (start) m_mode = M_RUN;
            default: m_mode = M_IDLE;
        endcase
    endtask

    // One clock: advance the model on the edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        mdl_update();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        mdl_reset();
        #30;
        arst = 1'b0;
        start = 0; stop = 0; load = 0; dir = 0; len = '0; load_val = '0;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        logic [W+2:0] exp;
        mdl_reset();
        #30;
        exp = {3'b000, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL reset_hold: got %b want %b", dut_out(), exp);
        end
        arst = 1'b0;
        tick();
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL reset_release: got %b want %b", dut_out(), exp);
        end
    endtask

    task automatic test_up_run();
        logic [W-1:0] ys [3] = '{3'b001, 3'b011, 3'b010};
        logic [W+2:0] exp;
        do_reset();
        start = 1; dir = 1; len = 3'd3;
        tick();
        start = 0; dir = 0; len = 3'd7;   // must be ignored mid-run
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {ys[i], (i != 2), (i == 2), 1'b0};
            vectors++;
            if (dut_out() !== exp) begin
                errors++; $display("FAIL up_run step%0d: got %b want %b", i, dut_out(), exp);
            end
        end
        tick();
        exp = {3'b010, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL up_run after: got %b want %b", dut_out(), exp);
        end
    endtask

    task automatic test_load_wrap();
        logic [W+2:0] exp;
        load = 1; load_val = 3'b100;
        tick();
        load = 0;
        exp = {3'b100, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL load: got %b want %b", dut_out(), exp);
        end
        start = 1; dir = 1; len = 3'd2;
        tick();
        start = 0;
        tick();
        exp = {3'b000, 1'b1, 1'b0, 1'b1};
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL load_wrap step0: got %b want %b", dut_out(), exp);
        end
        tick();
        exp = {3'b001, 1'b0, 1'b1, 1'b0};
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL load_wrap step1: got %b want %b", dut_out(), exp);
        end
    endtask

    task automatic test_down_wrap();
        logic [W+2:0] exp;
        do_reset();
        start = 1; dir = 0; len = 3'd1;
        tick();
        start = 0;
        tick();
        exp = {3'b100, 1'b0, 1'b1, 1'b1};
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL down_wrap: got %b want %b", dut_out(), exp);
        end
        tick();
        exp = {3'b100, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL down_wrap after: got %b want %b", dut_out(), exp);
        end
    endtask

    task automatic test_pause_resume_abort();
        logic [W-1:0] ys [3] = '{3'b011, 3'b010, 3'b110};
        logic [W+2:0] exp;
        do_reset();
        start = 1; dir = 1; len = 3'd4;
        tick();
        start = 0;
        tick();                         // first step -> 001
        stop = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) stop = 0;
            exp = {3'b001, 1'b1, 1'b0, 1'b0};
            vectors++;
            if (dut_out() !== exp) begin
                errors++; $display("FAIL hold cyc%0d: got %b want %b", i, dut_out(), exp);
            end
        end
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {ys[i], (i != 2), (i == 2), 1'b0};
            vectors++;
            if (dut_out() !== exp) begin
                errors++; $display("FAIL resume step%0d: got %b want %b", i, dut_out(), exp);
            end
        end
        // Repeat run, stop twice: pause then abort.
        tick();
        start = 1; dir = 1; len = 3'd4;
        tick();
        start = 0; stop = 1;
        tick();
        tick();
        stop = 0;
        exp = {3'b110, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL abort: got %b want %b", dut_out(), exp);
        end
        tick();
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL abort after: got %b want %b", dut_out(), exp);
        end
    endtask

    task automatic test_edge_cases();
        logic [W+2:0] exp;
        do_reset();
        load = 1; load_val = 3'b101;
        tick();
        load = 0;
        start = 1; len = 3'd0; dir = 1;
        tick();
        start = 0;
        exp = {3'b101, 1'b0, 1'b1, 1'b0};
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL len0: got %b want %b", dut_out(), exp);
        end
        tick();
        exp = {3'b101, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL len0 after: got %b want %b", dut_out(), exp);
        end
        start = 1; load = 1; load_val = 3'b011; len = 3'd3;
        tick();
        start = 0; load = 0;
        exp = {3'b011, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL start_load: got %b want %b", dut_out(), exp);
        end
        tick();
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL start_load after: got %b want %b", dut_out(), exp);
        end
    endtask

    task automatic test_reset_midrun();
        logic [W+2:0] exp;
        do_reset();
        start = 1; dir = 1; len = 3'd6;
        tick();
        start = 0;
        tick();
        tick();
        #2;
        arst = 1'b1;
        mdl_reset();
        #1;                             // well before the next edge
        exp = {3'b000, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (dut_out() !== exp) begin
            errors++; $display("FAIL async_reset: got %b want %b", dut_out(), exp);
        end
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (dut_out() !== exp) begin
                errors++; $display("FAIL post_reset cyc%0d: got %b want %b", i, dut_out(), exp);
            end
        end
    endtask

    task automatic test_random();
        logic [W+2:0] exp;
        logic [W-1:0] prev_y;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 7) == 0);
            load     = ($urandom_range(0, 9) == 0);
            dir      = $urandom_range(0, 1);
            len      = W'($urandom_range(0, MOD - 1));
            load_val = W'($urandom_range(0, MOD - 1));
            prev_y   = y;
            tick();
            exp = model_out();
            vectors++;
            if (dut_out() !== exp) begin
                errors++; $display("FAIL random cyc%0d: got %b want %b", i, dut_out(), exp);
            end
            if (m_stepped) begin
                vectors++;
                if ($countones(y ^ prev_y) != 1) begin
                    errors++;
                    $display("FAIL one_bit cyc%0d: %b -> %b changed %0d bits want 1",
                             i, prev_y, y, $countones(y ^ prev_y));
                end
            end
        end
        start = 0; stop = 0; load = 0;
    endtask

    initial begin
        test_reset();
        test_up_run();
        test_load_wrap();
        test_down_wrap();
        test_pause_resume_abort();
        test_edge_cases();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, want finish before 500000");
        $fatal(1);
    end

endmodule
